fu_issue_scheduler: RTL and testbench

- Sequences issue and completion for the reservation station's per-class FU slots (ALU, MULT, LOAD, STORE).
- Each RS entry i of a class is bound to FU slot i of that class. The block takes per-entry ready requests and grants at most one issue per cycle through round-robin class arbitration.
- Tracks each slot's execution latency and arbitrates the single CDB among finished slots.
- Generates the free_alu/free_mult/free_load/free_store pulses the RS consumes.

---
 rtl/fu_issue_scheduler.sv | 206 ++++++++++++++++++++
 tb/tb_fu_issue_scheduler.sv | 175 +++++++++++++++++
 2 files changed

// File: rtl/fu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : fu_issue_scheduler
// Purpose  : Issues one ready RS entry per cycle to its bound FU slot using
//            round-robin class arbitration. Times each slot's execution and
//            grants the single CDB to one finished slot per cycle, producing
//            the per-slot free pulses the RS consumes.
// Revision : 1.0  initial release
// ============================================================================
module fu_issue_scheduler #(
  parameter int NUM_ALU   = 2,
  parameter int NUM_MULT  = 2,
  parameter int NUM_LOAD  = 2,
  parameter int NUM_STORE = 2,
  parameter int ALU_LAT   = 1,
  parameter int MULT_LAT  = 4,
  parameter int LOAD_LAT  = 2,
  parameter int STORE_LAT = 1,
  parameter int IDX_W     = 1
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic [NUM_ALU-1:0]   req_alu,
  input  logic [NUM_MULT-1:0]  req_mult,
  input  logic [NUM_LOAD-1:0]  req_load,
  input  logic [NUM_STORE-1:0] req_store,
  input  logic                 issue_stall,
  input  logic                 squash,
  output logic                 issue_valid,
  output logic [1:0]           issue_funit,
  output logic [IDX_W-1:0]     issue_index,
  output logic                 cdb_valid,
  output logic [1:0]           cdb_funit,
  output logic [IDX_W-1:0]     cdb_index,
  output logic [NUM_ALU-1:0]   free_alu,
  output logic [NUM_MULT-1:0]  free_mult,
  output logic [NUM_LOAD-1:0]  free_load,
  output logic [NUM_STORE-1:0] free_store,
  output logic [NUM_ALU+NUM_MULT+NUM_LOAD+NUM_STORE-1:0] slot_busy
);

  // All slots are kept in one flat vector: ALU, then MULT, LOAD, STORE.
  localparam int NUM_TOT   = NUM_ALU + NUM_MULT + NUM_LOAD + NUM_STORE;
  localparam int OFF_MULT  = NUM_ALU;
  localparam int OFF_LOAD  = NUM_ALU + NUM_MULT;
  localparam int OFF_STORE = NUM_ALU + NUM_MULT + NUM_LOAD;
  localparam int MAX_AM    = (ALU_LAT > MULT_LAT) ? ALU_LAT : MULT_LAT;
  localparam int MAX_LS    = (LOAD_LAT > STORE_LAT) ? LOAD_LAT : STORE_LAT;
  localparam int MAX_LAT   = (MAX_AM > MAX_LS) ? MAX_AM : MAX_LS;
  localparam int CNT_W     = $clog2(MAX_LAT) + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } slot_state_t;

  slot_state_t          state [NUM_TOT];
  logic [CNT_W-1:0]     cnt   [NUM_TOT];
  logic [1:0]           ptr;
  logic [NUM_TOT-1:0]   free_all;
  logic [NUM_TOT-1:0]   req_all;
  logic [NUM_TOT-1:0]   elig;
  logic [NUM_TOT-1:0]   busy;

  logic                 iss_found;
  logic [1:0]           iss_funit;
  int                   iss_flat;
  logic                 grant;
  logic                 cdb_found;
  logic [1:0]           cdb_cls;
  int                   cdb_flat;

  function automatic logic [1:0] class_of(input int j);
    if (j < OFF_MULT)       return 2'd0;
    else if (j < OFF_LOAD)  return 2'd1;
    else if (j < OFF_STORE) return 2'd2;
    else                    return 2'd3;
  endfunction

  function automatic int off_of(input logic [1:0] c);
    case (c)
      2'd0:    return 0;
      2'd1:    return OFF_MULT;
      2'd2:    return OFF_LOAD;
      default: return OFF_STORE;
    endcase
  endfunction

  function automatic int lat_of(input logic [1:0] c);
    case (c)
      2'd0:    return ALU_LAT;
      2'd1:    return MULT_LAT;
      2'd2:    return LOAD_LAT;
      default: return STORE_LAT;
    endcase
  endfunction

  // CDB priority order: MULT first, then LOAD, then ALU.
  function automatic logic [1:0] cdb_order(input int p);
    case (p)
      0:       return 2'd1;
      1:       return 2'd2;
      default: return 2'd0;
    endcase
  endfunction

  assign req_all = {req_store, req_load, req_mult, req_alu};

  for (genvar g = 0; g < NUM_TOT; g++) begin : g_slot
    assign busy[g] = (state[g] != S_IDLE);
    assign elig[g] = req_all[g] && (state[g] == S_IDLE);
  end

  assign slot_busy  = busy;
  assign free_alu   = free_all[NUM_ALU-1:0];
  assign free_mult  = free_all[OFF_LOAD-1:OFF_MULT];
  assign free_load  = free_all[OFF_STORE-1:OFF_LOAD];
  assign free_store = free_all[NUM_TOT-1:OFF_STORE];

  // Issue pick: scan classes from the pointer, lowest eligible index wins.
  always_comb begin
    iss_found = 1'b0;
    iss_funit = 2'd0;
    iss_flat  = 0;
    for (int s = 0; s < 4; s++) begin
      for (int j = 0; j < NUM_TOT; j++) begin
        if (!iss_found && elig[j] && (class_of(j) == ptr + 2'(s))) begin
          iss_found = 1'b1;
          iss_funit = class_of(j);
          iss_flat  = j;
        end
      end
    end
  end

  assign grant = iss_found && !issue_stall;

  // CDB pick: fixed class priority over finished non-store slots.
  always_comb begin
    cdb_found = 1'b0;
    cdb_cls   = 2'd0;
    cdb_flat  = 0;
    for (int p = 0; p < 3; p++) begin
      for (int j = 0; j < NUM_TOT; j++) begin
        if (!cdb_found && (state[j] == S_DONE) && (class_of(j) == cdb_order(p))) begin
          cdb_found = 1'b1;
          cdb_cls   = cdb_order(p);
          cdb_flat  = j;
        end
      end
    end
  end

  // Slot FSMs, class pointer and all registered outputs.
  always_ff @(posedge clock) begin
    if (!reset || squash) begin
      for (int j = 0; j < NUM_TOT; j++) begin
        state[j] <= S_IDLE;
        cnt[j]   <= '0;
      end
      if (!reset) ptr <= 2'd0;
      issue_valid <= 1'b0;
      issue_funit <= 2'd0;
      issue_index <= '0;
      cdb_valid   <= 1'b0;
      cdb_funit   <= 2'd0;
      cdb_index   <= '0;
      free_all    <= '0;
    end else begin
      issue_valid <= grant;
      issue_funit <= grant ? iss_funit : 2'd0;
      issue_index <= grant ? IDX_W'(iss_flat - off_of(iss_funit)) : '0;
      if (grant) ptr <= iss_funit + 2'd1;

      cdb_valid <= cdb_found;
      cdb_funit <= cdb_found ? cdb_cls : 2'd0;
      cdb_index <= cdb_found ? IDX_W'(cdb_flat - off_of(cdb_cls)) : '0;

      free_all <= '0;
      for (int j = 0; j < NUM_TOT; j++) begin
        case (state[j])
          S_IDLE: begin
            if (grant && (iss_flat == j)) begin
              state[j] <= S_EXEC;
              cnt[j]   <= CNT_W'(lat_of(class_of(j)) - 1);
            end
          end
          S_EXEC: begin
            if (cnt[j] == '0) state[j] <= S_DONE;
            else              cnt[j]   <= cnt[j] - CNT_W'(1);
          end
          S_DONE: begin
            if ((class_of(j) == 2'd3) || (cdb_found && (cdb_flat == j))) begin
              state[j]    <= S_IDLE;
              free_all[j] <= 1'b1;
            end
          end
          default: state[j] <= S_IDLE;
        endcase
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_fu_issue_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : tb_fu_issue_scheduler
// Purpose  : Directed self-checking bench for fu_issue_scheduler with the
//            default configuration (2 slots per class, LAT 1/4/2/1).
// Revision : 1.0  initial release
// ============================================================================
module tb_fu_issue_scheduler;

  logic       clock = 1'b0;
  logic       reset;
  logic [1:0] req_alu, req_mult, req_load, req_store;
  logic       issue_stall, squash;
  logic       issue_valid, cdb_valid;
  logic [1:0] issue_funit, cdb_funit;
  logic       issue_index, cdb_index;
  logic [1:0] free_alu, free_mult, free_load, free_store;
  logic [7:0] slot_busy;
  logic [3:0] iss;
  logic [3:0] cdb;

  int n_chk  = 0;
  int n_pass = 0;

  fu_issue_scheduler dut (
    .clock      (clock),
    .reset      (reset),
    .req_alu    (req_alu),
    .req_mult   (req_mult),
    .req_load   (req_load),
    .req_store  (req_store),
    .issue_stall(issue_stall),
    .squash     (squash),
    .issue_valid(issue_valid),
    .issue_funit(issue_funit),
    .issue_index(issue_index),
    .cdb_valid  (cdb_valid),
    .cdb_funit  (cdb_funit),
    .cdb_index  (cdb_index),
    .free_alu   (free_alu),
    .free_mult  (free_mult),
    .free_load  (free_load),
    .free_store (free_store),
    .slot_busy  (slot_busy)
  );

  assign iss = {issue_valid, issue_funit, issue_index};
  assign cdb = {cdb_valid, cdb_funit, cdb_index};

  always #5 clock = ~clock;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic clr();
    req_alu = '0; req_mult = '0; req_load = '0; req_store = '0;
    issue_stall = 1'b0; squash = 1'b0;
  endtask

  task automatic do_reset();
    clr();
    reset = 1'b0;
    tick();
    tick();
    reset = 1'b1;
  endtask

  initial begin
    clr();
    reset = 1'b0;

    // Reset held with every request high.
    req_alu = 2'b11; req_mult = 2'b11; req_load = 2'b11; req_store = 2'b11;
    tick(); tick();
    check("rst_issue", iss, 4'h0);
    check("rst_cdb",   cdb, 4'h0);
    check("rst_busy",  slot_busy, 8'h00);
    check("rst_free",  {free_store, free_load, free_mult, free_alu}, 8'h00);
    reset = 1'b1;
    tick();
    check("rst_first_grant", iss, 4'b1_00_0);

    // Round-robin across classes; requests drop once granted.
    do_reset();
    req_alu = 2'b01; req_mult = 2'b01; req_load = 2'b01; req_store = 2'b01;
    tick(); check("rr_alu",   iss, 4'b1_00_0); req_alu   = '0;
    tick(); check("rr_mult",  iss, 4'b1_01_0); req_mult  = '0;
    tick(); check("rr_load",  iss, 4'b1_10_0); req_load  = '0;
    check("rr_alu_cdb", cdb, 4'b1_00_0);
    tick(); check("rr_store", iss, 4'b1_11_0); req_store = '0;
    check("rr_busy", slot_busy, 8'h54);
    tick(); check("rr_none", iss, 4'h0);

    // MULT latency: issue at c1, CDB and free at c6 only.
    do_reset();
    req_mult = 2'b01;
    tick(); check("lat_issue", iss, 4'b1_01_0); req_mult = '0;
    for (int k = 2; k <= 8; k++) begin
      tick();
      check($sformatf("lat_cdbv_c%0d", k), cdb_valid, (k == 6) ? 1'b1 : 1'b0);
      check($sformatf("lat_free_c%0d", k), free_mult, (k == 6) ? 2'b01 : 2'b00);
      if (k == 6) check("lat_cdb_funit", cdb_funit, 2'd1);
    end

    // CDB contention: LOAD0 and ALU0 finish together, LOAD goes first.
    do_reset();
    req_load = 2'b01;
    tick(); check("con_iss_load", iss, 4'b1_10_0); req_load = '0; req_alu = 2'b01;
    tick(); check("con_iss_alu",  iss, 4'b1_00_0); req_alu = '0;
    tick(); check("con_c3_cdb", cdb_valid, 1'b0);
    tick();
    check("con_c4_cdb",  cdb, 4'b1_10_0);
    check("con_c4_free", {free_load, free_alu}, 4'b01_00);
    tick();
    check("con_c5_cdb",  cdb, 4'b1_00_0);
    check("con_c5_free", {free_load, free_alu}, 4'b00_01);
    tick();
    check("con_c6_cdb",  cdb_valid, 1'b0);
    check("con_c6_free", {free_load, free_alu}, 4'b00_00);

    // STORE completes without the CDB.
    do_reset();
    req_store = 2'b10;
    for (int k = 1; k <= 5; k++) begin
      tick();
      if (k == 1) begin
        check("st_issue", iss, 4'b1_11_1);
        req_store = '0;
      end
      if (k == 2) check("st_busy", slot_busy[7], 1'b1);
      check($sformatf("st_cdb_c%0d", k),  cdb_valid, 1'b0);
      check($sformatf("st_free_c%0d", k), free_store, (k == 3) ? 2'b10 : 2'b00);
    end

    // Stall holds grants and the pointer (pointer sits at MULT).
    do_reset();
    req_alu = 2'b01;
    tick(); check("stl_first", iss, 4'b1_00_0);
    req_alu = 2'b10; req_mult = 2'b01; issue_stall = 1'b1;
    tick(); check("stl_hold1", iss, 4'h0);
    tick(); check("stl_hold2", iss, 4'h0);
    issue_stall = 1'b0;
    tick(); check("stl_mult", iss, 4'b1_01_0); req_mult = '0;
    tick(); check("stl_alu1", iss, 4'b1_00_1); req_alu = '0;

    // Squash with MULT in flight: no free pulse, slot reusable at once.
    do_reset();
    req_mult = 2'b01;
    tick(); check("sq_issue", iss, 4'b1_01_0); req_mult = '0;
    tick(); squash = 1'b1;
    tick();
    check("sq_busy",  slot_busy, 8'h00);
    check("sq_issue0", iss, 4'h0);
    check("sq_cdb0",   cdb, 4'h0);
    squash = 1'b0; req_mult = 2'b01;
    tick(); check("sq_regrant", iss, 4'b1_01_0); req_mult = '0;
    for (int k = 5; k <= 9; k++) begin
      tick();
      check($sformatf("sq_free_c%0d", k), free_mult, (k == 9) ? 2'b01 : 2'b00);
    end

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
`default_nettype wire
